// File: rtl/mix_param_loader.sv
// Host-to-RAM loader for the mix layer: streams W words then b words into the parameter RAM write ports.
// Optional running XOR of accepted words on the checksum port when MIX_PARAM_LOADER_CHECKSUM_EN is defined.

`ifndef DATA_N
`define DATA_N 8
`endif
`ifndef N_LEN_W
`define N_LEN_W 16
`endif
`ifndef HID_DIM
`define HID_DIM 16
`endif

module mix_param_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int W_WIDTH    = `DATA_N*`N_LEN_W,
  parameter int B_WIDTH    = `N_LEN_W,
  parameter int W_DEPTH    = 3*`HID_DIM*`HID_DIM/`DATA_N,
  parameter int B_DEPTH    = 3*`HID_DIM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  s_valid,
  input  logic [W_WIDTH-1:0]    s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  valid,
  output logic                  err,
  output logic                  load_w,
  output logic [ADDR_WIDTH-1:0] waddr_w,
  output logic [W_WIDTH-1:0]    wdata_w,
  output logic                  load_b,
  output logic [ADDR_WIDTH-1:0] waddr_b,
  output logic [B_WIDTH-1:0]    wdata_b
`ifdef MIX_PARAM_LOADER_CHECKSUM_EN
  ,
  output logic [W_WIDTH-1:0]    checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(W_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] B_LAST = ADDR_WIDTH'(B_DEPTH - 1);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                    w_beat, b_beat, final_beat;

  logic                    load_w_reg, load_b_reg, valid_reg, err_reg;
  logic [ADDR_WIDTH-1:0]   waddr_w_reg, waddr_b_reg;
  logic [W_WIDTH-1:0]      wdata_w_reg;
  logic [B_WIDTH-1:0]      wdata_b_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    s_ready    = 1'b0;
    w_beat     = 1'b0;
    b_beat     = 1'b0;
    final_beat = 1'b0;
    if (!run) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = LOAD_W;
          cnt_next   = '0;
        end
        LOAD_W: begin
          s_ready = 1'b1;
          if (s_valid) begin
            w_beat = 1'b1;
            if (cnt_reg == W_LAST) begin
              state_next = LOAD_B;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        LOAD_B: begin
          s_ready = 1'b1;
          if (s_valid) begin
            b_beat = 1'b1;
            if (cnt_reg == B_LAST) begin
              final_beat = 1'b1;
              state_next = DONE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      load_w_reg  <= 1'b0;
      load_b_reg  <= 1'b0;
      waddr_w_reg <= '0;
      wdata_w_reg <= '0;
      waddr_b_reg <= '0;
      wdata_b_reg <= '0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      load_w_reg <= w_beat;
      load_b_reg <= b_beat;
      // Address/data hold their last value between writes
      if (w_beat) begin
        waddr_w_reg <= cnt_reg;
        wdata_w_reg <= s_data;
      end
      if (b_beat) begin
        waddr_b_reg <= cnt_reg;
        wdata_b_reg <= s_data[B_WIDTH-1:0];
      end
      valid_reg <= (state_next == DONE);
      if (!run) begin
        err_reg <= 1'b0;
      end else if ((w_beat || b_beat) && (s_last != final_beat)) begin
        err_reg <= 1'b1;
      end
    end
  end

`ifdef MIX_PARAM_LOADER_CHECKSUM_EN
  logic [W_WIDTH-1:0] b_ext;
  logic [W_WIDTH-1:0] checksum_reg;

  for (genvar gi = 0; gi < W_WIDTH; gi++) begin : g_b_ext
    if (gi < B_WIDTH) begin : g_keep
      assign b_ext[gi] = s_data[gi];
    end else begin : g_zero
      assign b_ext[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run || state_reg == IDLE) begin
      checksum_reg <= '0;
    end else if (w_beat) begin
      checksum_reg <= checksum_reg ^ s_data;
    end else if (b_beat) begin
      checksum_reg <= checksum_reg ^ b_ext;
    end
  end

  assign checksum = checksum_reg;
`endif

  assign valid   = valid_reg;
  assign err     = err_reg;
  assign load_w  = load_w_reg;
  assign waddr_w = waddr_w_reg;
  assign wdata_w = wdata_w_reg;
  assign load_b  = load_b_reg;
  assign waddr_b = waddr_b_reg;
  assign wdata_b = wdata_b_reg;

endmodule
